uart_tx_feeder: RTL and testbench

//  Byte FIFO and pacer directly upstream of UART_tx. Buffers bytes from core logic, issues them
//  to the transmitter as single-cycle tx_data_valid pulses spaced BYTE_CYCLES clocks apart.

---
 rtl/uart_tx_feeder.sv | 91 +++++++++
 tb/tb_uart_tx_feeder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus pacer in front of UART_tx: buffers core bytes and issues them as
// single-cycle tx_data_valid strobes spaced exactly BYTE_CYCLES clocks apart.
module uart_tx_feeder #(
  parameter int ADDR_W      = 4,
  parameter int BYTE_CYCLES = 4774
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              wr_drop,
  output logic              busy,
  output logic              tx_data_valid,
  output logic [7:0]        tx_data
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [ADDR_W:0]  FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BYTE_CYCLES - 2);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  state_t            state;
  logic              push, pop;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign busy  = (state != S_IDLE) || !empty;
  // Full check ignores a same-cycle pop: a write at full is always rejected.
  assign push  = wr_en && !full;
  assign pop   = (state == S_ISSUE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Strobe and data register on the S_ISSUE edge, giving 2-clock write-to-pulse latency
  // and BYTE_CYCLES spacing (1 issue + BYTE_CYCLES-2 countdown + 1 zero-detect).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      tx_data_valid <= 1'b0;
      tx_data       <= 8'h00;
    end else begin
      tx_data_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!empty) state <= S_ISSUE;
        end
        S_ISSUE: begin
          tx_data_valid <= 1'b1;
          tx_data       <= mem[rd_ptr];
          cnt           <= CNT_LOAD;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) state <= empty ? S_IDLE : S_ISSUE;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: A instance at the default pacing, B instance with
// BYTE_CYCLES=8 for the fill/overflow/reset scenarios.
module tb_uart_tx_feeder;

  localparam int BC_A = 4774;
  localparam int BC_B = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       a_wr_en, b_wr_en;
  logic [7:0] a_wr_data, b_wr_data;
  logic       a_full, a_empty, a_wr_drop, a_busy, a_tx_data_valid;
  logic       b_full, b_empty, b_wr_drop, b_busy, b_tx_data_valid;
  logic [4:0] a_level, b_level;
  logic [7:0] a_tx_data, b_tx_data;

  int vecs = 0;
  int errs = 0;

  int         a_npulse = 0, a_b2b = 0, b_b2b = 0;
  logic       a_prev = 1'b0, b_prev = 1'b0;
  logic [7:0] b_got [$];

  always #5 clk = ~clk;

  uart_tx_feeder #(.ADDR_W(4), .BYTE_CYCLES(BC_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .wr_en(a_wr_en), .wr_data(a_wr_data),
    .full(a_full), .empty(a_empty), .level(a_level), .wr_drop(a_wr_drop),
    .busy(a_busy), .tx_data_valid(a_tx_data_valid), .tx_data(a_tx_data));

  uart_tx_feeder #(.ADDR_W(4), .BYTE_CYCLES(BC_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .full(b_full), .empty(b_empty), .level(b_level), .wr_drop(b_wr_drop),
    .busy(b_busy), .tx_data_valid(b_tx_data_valid), .tx_data(b_tx_data));

  always @(negedge clk) begin
    if (a_tx_data_valid) a_npulse++;
    if (a_tx_data_valid && a_prev) a_b2b++;
    a_prev = a_tx_data_valid;
    if (b_tx_data_valid) b_got.push_back(b_tx_data);
    if (b_tx_data_valid && b_prev) b_b2b++;
    b_prev = b_tx_data_valid;
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_wr_en = i[0]; b_wr_en = i[0]; a_wr_data = 8'hA0; b_wr_data = 8'hB0;
      cyc();
    end
    a_wr_en = 1'b0; b_wr_en = 1'b0;
    vecs++; if (a_empty !== 1'b1 || a_level !== 5'd0 || a_full !== 1'b0) begin errs++;
      $display("FAIL reset_a_fifo: empty=%b level=%0d full=%b, want 1/0/0", a_empty, a_level, a_full); end
    vecs++; if (a_tx_data_valid !== 1'b0 || a_tx_data !== 8'h00 || a_busy !== 1'b0 || a_wr_drop !== 1'b0) begin errs++;
      $display("FAIL reset_a_out: valid=%b data=%h busy=%b drop=%b, want 0/00/0/0", a_tx_data_valid, a_tx_data, a_busy, a_wr_drop); end
    vecs++; if (b_empty !== 1'b1 || b_level !== 5'd0 || b_tx_data_valid !== 1'b0 || b_tx_data !== 8'h00) begin errs++;
      $display("FAIL reset_b: empty=%b level=%0d valid=%b data=%h, want 1/0/0/00", b_empty, b_level, b_tx_data_valid, b_tx_data); end
    reset_n = 1'b1;
    cyc(12);
    vecs++; if (a_npulse !== 0 || b_got.size() !== 0) begin errs++;
      $display("FAIL reset_no_pulse: a=%0d b=%0d pulses, want 0/0", a_npulse, b_got.size()); end
  endtask

  task automatic test_single;
    int n;
    a_wr_en = 1'b1; a_wr_data = 8'h55;
    cyc();                      // edge k
    a_wr_en = 1'b0;
    vecs++; if (a_tx_data_valid !== 1'b0 || a_busy !== 1'b1 || a_level !== 5'd1) begin errs++;
      $display("FAIL single_k: valid=%b busy=%b level=%0d, want 0/1/1", a_tx_data_valid, a_busy, a_level); end
    cyc();                      // edge k+1
    vecs++; if (a_tx_data_valid !== 1'b0) begin errs++;
      $display("FAIL single_k1: valid=%b, want 0", a_tx_data_valid); end
    cyc();                      // edge k+2
    vecs++; if (a_tx_data_valid !== 1'b1 || a_tx_data !== 8'h55) begin errs++;
      $display("FAIL single_k2: valid=%b data=%h, want 1/55", a_tx_data_valid, a_tx_data); end
    n = 0;
    while (n < 6000) begin
      cyc(); n++;
      if (!a_busy) break;
    end
    vecs++; if (n !== BC_A - 1) begin errs++;
      $display("FAIL single_busy: busy fell %0d clocks after pulse, want %0d", n, BC_A - 1); end
    vecs++; if (a_npulse !== 1 || a_tx_data !== 8'h55) begin errs++;
      $display("FAIL single_count: pulses=%0d data=%h, want 1/55", a_npulse, a_tx_data); end
  endtask

  task automatic test_back_to_back;
    int np, hold_err, n;
    int   p_idx [4];
    logic [7:0] p_dat [4];
    logic [7:0] exp_hold;
    np = 0; hold_err = 0;
    for (int i = 0; i < 3; i++) begin
      a_wr_en = 1'b1; a_wr_data = 8'h41 + i[7:0]; cyc();
    end
    a_wr_en = 1'b0;
    vecs++; if (a_tx_data_valid !== 1'b1 || a_tx_data !== 8'h41) begin errs++;
      $display("FAIL b2b_first: valid=%b data=%h, want 1/41", a_tx_data_valid, a_tx_data); end
    for (int i = 1; i <= 2*BC_A + 5; i++) begin
      cyc();
      if (a_tx_data_valid) begin
        if (np < 4) begin p_idx[np] = i; p_dat[np] = a_tx_data; end
        np++;
      end else begin
        exp_hold = (np == 0) ? 8'h41 : (np == 1) ? 8'h42 : 8'h43;
        if (a_tx_data !== exp_hold) hold_err++;
      end
    end
    vecs++; if (np !== 2) begin errs++;
      $display("FAIL b2b_count: %0d later pulses, want 2", np); end
    if (np >= 2) begin
      vecs++; if (p_idx[0] !== BC_A || p_dat[0] !== 8'h42) begin errs++;
        $display("FAIL b2b_second: at +%0d data=%h, want +%0d/42", p_idx[0], p_dat[0], BC_A); end
      vecs++; if (p_idx[1] !== 2*BC_A || p_dat[1] !== 8'h43) begin errs++;
        $display("FAIL b2b_third: at +%0d data=%h, want +%0d/43", p_idx[1], p_dat[1], 2*BC_A); end
    end
    vecs++; if (hold_err !== 0 || a_b2b !== 0) begin errs++;
      $display("FAIL b2b_hold: %0d hold errors, %0d adjacent strobes, want 0/0", hold_err, a_b2b); end
    n = 0;
    while (a_busy && n < 6000) begin cyc(); n++; end
    vecs++; if (a_busy !== 1'b0) begin errs++;
      $display("FAIL b2b_idle: busy=%b after %0d clocks, want 0", a_busy, n); end
  endtask

  // Writes every edge from edge 0; pops land on edges 2,10,18,26,34.
  task automatic test_full_drop;
    for (int n = 0; n < 18; n++) begin
      b_wr_en = 1'b1; b_wr_data = 8'h10 + n[7:0]; cyc();
    end
    b_wr_en = 1'b0;
    vecs++; if (b_level !== 5'd16 || b_full !== 1'b1 || b_empty !== 1'b0) begin errs++;
      $display("FAIL fill: level=%0d full=%b empty=%b, want 16/1/0", b_level, b_full, b_empty); end
    cyc();                      // edge 18: pop
    vecs++; if (b_level !== 5'd15 || b_full !== 1'b0 || b_tx_data_valid !== 1'b1 || b_tx_data !== 8'h12) begin errs++;
      $display("FAIL fill_pop: level=%0d full=%b valid=%b data=%h, want 15/0/1/12", b_level, b_full, b_tx_data_valid, b_tx_data); end
    b_wr_en = 1'b1; b_wr_data = 8'h22; cyc();   // edge 19
    vecs++; if (b_level !== 5'd16 || b_full !== 1'b1 || b_wr_drop !== 1'b0) begin errs++;
      $display("FAIL refill: level=%0d full=%b drop=%b, want 16/1/0", b_level, b_full, b_wr_drop); end
    b_wr_data = 8'hEE; cyc();                    // edge 20: rejected
    b_wr_en = 1'b0;
    vecs++; if (b_wr_drop !== 1'b1 || b_level !== 5'd16) begin errs++;
      $display("FAIL drop: drop=%b level=%0d, want 1/16", b_wr_drop, b_level); end
    cyc();                                       // edge 21
    vecs++; if (b_wr_drop !== 1'b0 || b_level !== 5'd16) begin errs++;
      $display("FAIL drop_pulse: drop=%b level=%0d, want 0/16", b_wr_drop, b_level); end
  endtask

  task automatic test_full_pop;
    cyc(4);                                      // edges 22..25
    b_wr_en = 1'b1; b_wr_data = 8'hDD; cyc();    // edge 26: pop + write while full
    b_wr_en = 1'b0;
    vecs++; if (b_level !== 5'd15 || b_wr_drop !== 1'b1 || b_tx_data_valid !== 1'b1) begin errs++;
      $display("FAIL full_pop: level=%0d drop=%b valid=%b, want 15/1/1", b_level, b_wr_drop, b_tx_data_valid); end
    cyc(7);                                      // edges 27..33
    b_wr_en = 1'b1; b_wr_data = 8'h23; cyc();    // edge 34: pop + write at 15
    b_wr_en = 1'b0;
    vecs++; if (b_level !== 5'd15 || b_wr_drop !== 1'b0 || b_tx_data_valid !== 1'b1) begin errs++;
      $display("FAIL l15_pop: level=%0d drop=%b valid=%b, want 15/0/1", b_level, b_wr_drop, b_tx_data_valid); end
  endtask

  task automatic test_drain_order;
    int n, bad;
    logic [7:0] exp_b;
    n = 0; bad = 0;
    while (b_busy && n < 400) begin cyc(); n++; end
    vecs++; if (b_busy !== 1'b0 || b_got.size() !== 20) begin errs++;
      $display("FAIL drain: busy=%b issued=%0d, want 0/20", b_busy, b_got.size()); end
    for (int i = 0; i < 20 && i < b_got.size(); i++) begin
      exp_b = (i < 18) ? 8'h10 + i[7:0] : (i == 18) ? 8'h22 : 8'h23;
      if (b_got[i] !== exp_b) bad++;
    end
    vecs++; if (bad !== 0 || b_b2b !== 0) begin errs++;
      $display("FAIL order: %0d wrong bytes, %0d adjacent strobes, want 0/0", bad, b_b2b); end
    b_got.delete();
  endtask

  task automatic test_reset_mid;
    for (int n = 0; n < 6; n++) begin
      b_wr_en = 1'b1; b_wr_data = 8'h30 + n[7:0]; cyc();
    end
    b_wr_en = 1'b0;
    vecs++; if (b_level !== 5'd5 || b_got.size() !== 1) begin errs++;
      $display("FAIL mid_pre: level=%0d issued=%0d, want 5/1", b_level, b_got.size()); end
    reset_n = 1'b0; #1;
    vecs++; if (b_level !== 5'd0 || b_empty !== 1'b1 || b_tx_data_valid !== 1'b0) begin errs++;
      $display("FAIL mid_async: level=%0d empty=%b valid=%b, want 0/1/0", b_level, b_empty, b_tx_data_valid); end
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    vecs++; if (b_got.size() !== 1 || b_busy !== 1'b0 || b_level !== 5'd0) begin errs++;
      $display("FAIL mid_quiet: issued=%0d busy=%b level=%0d, want 1/0/0", b_got.size(), b_busy, b_level); end
    b_wr_en = 1'b1; b_wr_data = 8'h77; cyc();    // edge k
    b_wr_en = 1'b0;
    cyc();                                       // edge k+1
    vecs++; if (b_tx_data_valid !== 1'b0) begin errs++;
      $display("FAIL mid_k1: valid=%b, want 0", b_tx_data_valid); end
    cyc();                                       // edge k+2
    vecs++; if (b_tx_data_valid !== 1'b1 || b_tx_data !== 8'h77 || b_level !== 5'd0) begin errs++;
      $display("FAIL mid_k2: valid=%b data=%h level=%0d, want 1/77/0", b_tx_data_valid, b_tx_data, b_level); end
  endtask

  initial begin
    a_wr_en = 1'b0; b_wr_en = 1'b0; a_wr_data = 8'h00; b_wr_data = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_full_drop;
    test_full_pop;
    test_drain_order;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
